// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, datapath defaults, FSM state type.
// Latency: none (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DW_DEF  = 8;
    localparam int OPW_DEF = 3;

    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_RLS  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes plus the ALU operand/result wires.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready toward requesters, resp_valid/resp_ready back.
// Ports: master = requesters and ALU side, slave = the arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = DW_DEF,
    parameter int OPW     = OPW_DEF
);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*OPW-1:0] req_op;
    logic [NUM_REQ*DW-1:0]  req_a;
    logic [NUM_REQ*DW-1:0]  req_b;
    logic [NUM_REQ-1:0]     resp_valid;
    logic [NUM_REQ-1:0]     resp_ready;
    logic [DW-1:0]          resp_result;
    logic                   resp_zero;
    logic                   resp_err;
    logic [OPW-1:0]         alu_instruction;
    logic [DW-1:0]          alu_input1;
    logic [DW-1:0]          alu_input2;
    logic [DW-1:0]          alu_result;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_result,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_err,
               alu_instruction, alu_input1, alu_input2
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_result,
        output req_ready, resp_valid, resp_result, resp_zero, resp_err,
               alu_instruction, alu_input1, alu_input2
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is used.
// Ports: req_i request vector, ptr_i start index, gnt_oh_o/gnt_idx_o grant, gnt_vld_o any grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IW-1:0]      gnt_idx_o,
    output logic               gnt_vld_o
);

    int idx;

    // Walk from the farthest candidate toward the pointer so the one
    // closest to the pointer is written last and wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'(idx);
                gnt_oh_o  = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, round-robin granted.
// Latency: grant 1 cycle after request sample, resp_valid 2 cycles after grant.
// Backpressure: response held until the granted requester's resp_ready; no new grant meanwhile.
// Ports: clk, reset_n (sync, active low), bus (alu_arbiter_if.slave).
// Option: ALU_ARB_OPCHK_EN flags opcodes > OP_RLS as errors and bypasses the ALU for them.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = DW_DEF,
    parameter int OPW     = OPW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_arbiter_if.slave  bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    alu_arb_state_t     state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [OPW-1:0]     op_q, op_d;
    logic [DW-1:0]      a_q, a_d;
    logic [DW-1:0]      b_q, b_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DW-1:0]      resp_result_q, resp_result_d;
    logic               resp_zero_q, resp_zero_d;
`ifdef ALU_ARB_OPCHK_EN
    logic               resp_err_q, resp_err_d;
`endif

    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_vld;
    logic [OPW-1:0]     sel_op;
    logic [DW-1:0]      sel_a;
    logic [DW-1:0]      sel_b;
    logic [NUM_REQ-1:0] gidx_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    assign sel_op  = bus.req_op[int'(arb_idx) * OPW +: OPW];
    assign sel_a   = bus.req_a[int'(arb_idx) * DW +: DW];
    assign sel_b   = bus.req_b[int'(arb_idx) * DW +: DW];
    assign gidx_oh = NUM_REQ'(1) << gidx_q;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        gidx_d        = gidx_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        req_ready_d   = '0;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
`ifdef ALU_ARB_OPCHK_EN
        resp_err_d    = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    req_ready_d = arb_oh;
                    gidx_d      = arb_idx;
`ifdef ALU_ARB_OPCHK_EN
                    if (sel_op > OPW'(OP_RLS)) begin
                        // Illegal opcode: answer directly, ALU inputs untouched.
                        resp_result_d = '1;
                        resp_zero_d   = 1'b0;
                        resp_err_d    = 1'b1;
                        state_d       = RESP;
                    end else begin
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        state_d = EXEC;
                    end
`else
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = EXEC;
`endif
                end
            end
            EXEC: begin
                resp_result_d = bus.alu_result;
                resp_zero_d   = (bus.alu_result == '0);
`ifdef ALU_ARB_OPCHK_EN
                resp_err_d    = 1'b0;
`endif
                state_d       = RESP;
            end
            RESP: begin
                // resp_valid is raised one cycle into RESP; only the granted
                // bit of resp_ready can complete the handshake.
                if ((resp_valid_q & bus.resp_ready) != '0) begin
                    rr_d    = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    resp_valid_d = gidx_oh;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            gidx_q        <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            req_ready_q   <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            resp_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            gidx_q        <= gidx_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
`ifdef ALU_ARB_OPCHK_EN
            resp_err_q    <= resp_err_d;
`endif
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_result     = resp_result_q;
    assign bus.resp_zero       = resp_zero_q;
    assign bus.alu_instruction = op_q;
    assign bus.alu_input1      = a_q;
    assign bus.alu_input2      = b_q;
`ifdef ALU_ARB_OPCHK_EN
    assign bus.resp_err        = resp_err_q;
`else
    assign bus.resp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU attached.
// Latency: n/a.
// Backpressure: exercises held responses and ignored resp_ready on non-granted bits.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NR  = 2;
    localparam int DW  = 8;
    localparam int OPW = 3;

`ifdef ALU_ARB_OPCHK_EN
    localparam logic       ILL_ERR   = 1'b1;
    localparam int         ILL_LAT   = 2;
    localparam logic [2:0] ILL_ALUOP = 3'd4;
    localparam logic [7:0] ILL_ALUA  = 8'h81;
`else
    localparam logic       ILL_ERR   = 1'b0;
    localparam int         ILL_LAT   = 3;
    localparam logic [2:0] ILL_ALUOP = 3'd6;
    localparam logic [7:0] ILL_ALUA  = 8'h12;
`endif

    logic clk;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;

    alu_arbiter_if #(.NUM_REQ(NR), .DW(DW), .OPW(OPW)) bus ();

    alu_arbiter #(.NUM_REQ(NR), .DW(DW), .OPW(OPW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: xor, compare (difference), add, and, rotate-left by b[2:0].
    logic [15:0] rot_tmp;
    always_comb begin
        rot_tmp = {bus.alu_input1, bus.alu_input1} << bus.alu_input2[2:0];
        case (bus.alu_instruction)
            3'd0:    bus.alu_result = bus.alu_input1 ^ bus.alu_input2;
            3'd1:    bus.alu_result = bus.alu_input1 - bus.alu_input2;
            3'd2:    bus.alu_result = bus.alu_input1 + bus.alu_input2;
            3'd3:    bus.alu_result = bus.alu_input1 & bus.alu_input2;
            3'd4:    bus.alu_result = rot_tmp[15:8];
            default: bus.alu_result = 8'hFF;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_resp_result"}, bus.resp_result, 0);
        chk({tag, "_resp_zero"}, bus.resp_zero, 0);
        chk({tag, "_resp_err"}, bus.resp_err, 0);
        chk({tag, "_alu_instr"}, bus.alu_instruction, 0);
        chk({tag, "_alu_in1"}, bus.alu_input1, 0);
        chk({tag, "_alu_in2"}, bus.alu_input2, 0);
    endtask

    task automatic wait_ready(input logic [1:0] exp, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_ready == 0 && n < 20);
        chk(tag, bus.req_ready, exp);
    endtask

    task automatic wait_resp(input logic [1:0] exp, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.resp_valid == 0 && n < 20);
        chk(tag, bus.resp_valid, exp);
    endtask

    task automatic accept(input logic [1:0] m, input string tag);
        bus.resp_ready = m;
        tick();
        chk({tag, "_resp_clear"}, bus.resp_valid, 0);
        bus.resp_ready = 2'b00;
    endtask

    // One isolated transaction; latency counted from req_valid assertion to resp_valid seen.
    task automatic txn(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ez, input logic ee, input int elat,
                       input string tag);
        int         n;
        logic [1:0] m;
        m = 2'(1 << r);
        bus.req_op[r*OPW +: OPW] = op;
        bus.req_a[r*DW +: DW]    = a;
        bus.req_b[r*DW +: DW]    = b;
        bus.req_valid[r]         = 1'b1;
        tick();
        n = 1;
        chk({tag, "_rdy"}, bus.req_ready, m);
        bus.req_valid[r] = 1'b0;
        tick();
        n = 2;
        chk({tag, "_rdy_one_cycle"}, bus.req_ready, 0);
        while (bus.resp_valid == 0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_valid"}, bus.resp_valid, m);
        chk({tag, "_result"}, bus.resp_result, er);
        chk({tag, "_zero"}, bus.resp_zero, ez);
        chk({tag, "_err"}, bus.resp_err, ee);
        accept(m, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset_n        = 1'b0;
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Tie right after reset: requester 0 first, then 1.
        bus.req_op = {OP_ANDI, OP_ADDI};
        bus.req_a  = {8'hF0, 8'h10};
        bus.req_b  = {8'h3C, 8'h20};
        bus.req_valid = 2'b11;
        wait_ready(2'b01, "tie_grant0");
        bus.req_valid[0] = 1'b0;
        wait_resp(2'b01, "tie_resp0");
        chk("tie_result0", bus.resp_result, 8'h30);
        accept(2'b01, "tie0");
        wait_ready(2'b10, "tie_grant1");
        bus.req_valid[1] = 1'b0;
        wait_resp(2'b10, "tie_resp1");
        chk("tie_result1", bus.resp_result, 8'h30);
        accept(2'b10, "tie1");

        // Fairness: both always valid, grants must alternate 0,1,0,1,0,1.
        bus.req_op = {OP_XOR, OP_ADDI};
        bus.req_a  = {8'h3C, 8'h01};
        bus.req_b  = {8'h0F, 8'h02};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] e;
            e = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_ready(e, "fair_grant");
            wait_resp(e, "fair_resp");
            chk("fair_result", bus.resp_result, (e == 2'b01) ? 8'h03 : 8'h33);
            accept(e, "fair");
        end
        bus.req_valid = 2'b00;

        // Single request, plain XOR.
        txn(0, OP_XOR, 8'h5A, 8'h0F, 8'h55, 1'b0, 1'b0, 3, "xor");

        // Backpressure on requester 1 with a competing, ignored resp_ready[0].
        bus.req_op[3 +: 3] = OP_BEQ;
        bus.req_a[8 +: 8]  = 8'h22;
        bus.req_b[8 +: 8]  = 8'h22;
        bus.req_valid      = 2'b10;
        wait_ready(2'b10, "bp_grant1");
        bus.req_valid = 2'b00;
        wait_resp(2'b10, "bp_resp1");
        bus.req_op[0 +: 3] = OP_XOR;
        bus.req_a[0 +: 8]  = 8'hAA;
        bus.req_b[0 +: 8]  = 8'h55;
        bus.req_valid      = 2'b01;
        bus.resp_ready     = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", bus.resp_valid, 2'b10);
            chk("bp_no_grant", bus.req_ready, 2'b00);
            chk("bp_hold_result", bus.resp_result, 8'h00);
            chk("bp_hold_zero", bus.resp_zero, 1'b1);
        end
        accept(2'b10, "bp1");
        wait_ready(2'b01, "bp_grant0");
        bus.req_valid = 2'b00;
        wait_resp(2'b01, "bp_resp0");
        chk("bp_result0", bus.resp_result, 8'hFF);
        accept(2'b01, "bp0");

        // Rotate left.
        txn(0, OP_RLS, 8'h81, 8'h01, 8'h03, 1'b0, 1'b0, 3, "rls_by1");
        txn(0, OP_RLS, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 3, "rls_by0");

        // Illegal opcode 6.
        txn(0, 3'd6, 8'h12, 8'h34, 8'hFF, 1'b0, ILL_ERR, ILL_LAT, "illegal");
        chk("illegal_alu_op", bus.alu_instruction, ILL_ALUOP);
        chk("illegal_alu_a", bus.alu_input1, ILL_ALUA);

        // Reset while the transaction is in EXEC.
        bus.req_op[0 +: 3] = OP_XOR;
        bus.req_a[0 +: 8]  = 8'h12;
        bus.req_b[0 +: 8]  = 8'h34;
        bus.req_valid      = 2'b01;
        tick();
        chk("mid_grant", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;
        reset_n = 1'b0;
        tick();
        chk_all_zero("mid_reset");
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.resp_valid != 0 || bus.req_ready != 0) seen = 1'b1;
        end
        chk("mid_no_resp", seen, 1'b0);

        // Recovery after reset; ADDI wrap-around gives a zero result.
        txn(1, OP_ADDI, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 3, "recover");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
